// File: rtl/id_inst_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry circular buffer of {pc, inst}
// words with valid/ready on both sides and branch flush with optional delay-slot keep.
module id_inst_queue #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 64,
  parameter int KEEP_DS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     flush,
  input  logic                     flush_keep,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ds_pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_adv;
  logic [PW-1:0]     wr_ptr_nx;
  logic [PW-1:0]     rd_ptr_nx;
  logic              push;
  logic              pop;
  logic              keep_flush;
  logic              full_flush;
  logic              retain;
  logic              we;
  logic              ds_nx;

  // Pointers carry a wrap bit so full and empty are told apart without a counter.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count     = wr_ptr - rd_ptr;
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];

  assign push       = in_valid & in_ready & ~rst;
  assign pop        = out_valid & out_ready & ~rst;
  assign keep_flush = flush & flush_keep & (KEEP_DS != 0);
  assign full_flush = flush & ~keep_flush;

  // The retained delay slot already sits at rd_adv, so keeping it only moves wr_ptr.
  always_comb begin
    rd_adv    = pop ? rd_ptr + PW'(1) : rd_ptr;
    retain    = (rd_adv != wr_ptr);
    wr_ptr_nx = wr_ptr;
    rd_ptr_nx = rd_adv;
    we        = 1'b0;
    ds_nx     = ds_pending;
    if (full_flush) begin
      rd_ptr_nx = wr_ptr;
      ds_nx     = 1'b0;
    end else if (keep_flush) begin
      if (retain) begin
        wr_ptr_nx = rd_adv + PW'(1);
        ds_nx     = 1'b0;
      end else if (push) begin
        we        = 1'b1;
        wr_ptr_nx = wr_ptr + PW'(1);
        ds_nx     = 1'b0;
      end else begin
        ds_nx     = 1'b1;
      end
    end else if (push) begin
      we        = 1'b1;
      wr_ptr_nx = wr_ptr + PW'(1);
      ds_nx     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ds_pending <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nx;
      rd_ptr     <= rd_ptr_nx;
      ds_pending <= ds_nx;
    end
  end

  // Entry 0 is cleared so the head mux is X-free straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
    end else if (we) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_id_inst_queue.sv
// Directed bench for id_inst_queue: one KEEP_DS=1 instance and one KEEP_DS=0
// instance share stimulus; expected values are hand-computed per step.
module tb_id_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;
  logic        flush;
  logic        flush_keep;

  logic        in_ready, out_valid, full, empty, ds_pending;
  logic [63:0] out_data;
  logic [2:0]  count;

  logic        in_ready0, out_valid0, full0, empty0, ds_pending0;
  logic [63:0] out_data0;
  logic [2:0]  count0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_inst_queue #(.DEPTH(4), .DATA_W(64), .KEEP_DS(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .flush_keep(flush_keep),
    .count(count), .full(full), .empty(empty), .ds_pending(ds_pending)
  );

  id_inst_queue #(.DEPTH(4), .DATA_W(64), .KEEP_DS(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .flush(flush), .flush_keep(flush_keep),
    .count(count0), .full(full0), .empty(empty0), .ds_pending(ds_pending0)
  );

  function automatic logic [63:0] mk(input logic [31:0] pc);
    return {pc, pc ^ 32'h1234_5678};
  endfunction

  // Drive one cycle of inputs, then land 1ns after the edge for sampling.
  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic r,
                               input logic f, input logic k);
    in_valid   = v;
    in_data    = d;
    out_ready  = r;
    flush      = f;
    flush_keep = k;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_empty", 64'(empty), 64'd1);
    checkOutput("rst_full", 64'(full), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_ds", 64'(ds_pending), 64'd0);
    checkOutput("rst_out_data", out_data, 64'd0);
    rst = 1'b0;

    // Fill to full with decode stalled, then overflow attempt and drain.
    applyStimulus(1'b1, mk(32'hBFC0_0000), 1'b0, 1'b0, 1'b0);
    checkOutput("fill_valid1", 64'(out_valid), 64'd1);
    checkOutput("fill_head1", out_data, mk(32'hBFC0_0000));
    for (int i = 1; i < 4; i++)
      applyStimulus(1'b1, mk(32'hBFC0_0000 + 32'(4 * i)), 1'b0, 1'b0, 1'b0);
    checkOutput("fill_full", 64'(full), 64'd1);
    checkOutput("fill_in_ready", 64'(in_ready), 64'd0);
    checkOutput("fill_count", 64'(count), 64'd4);
    applyStimulus(1'b1, mk(32'hBFC0_0010), 1'b0, 1'b0, 1'b0);
    checkOutput("overflow_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain_head%0d", i), out_data, mk(32'hBFC0_0000 + 32'(4 * i)));
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("drain_empty", 64'(empty), 64'd1);
    checkOutput("drain_count", 64'(count), 64'd0);

    // Streaming push+pop every cycle across several pointer wraps.
    applyStimulus(1'b1, mk(32'h1000), 1'b1, 1'b0, 1'b0);
    checkOutput("stream_count0", 64'(count), 64'd1);
    for (int i = 1; i < 20; i++) begin
      applyStimulus(1'b1, mk(32'h1000 + 32'(4 * i)), 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("stream_count%0d", i), 64'(count), 64'd1);
      checkOutput($sformatf("stream_head%0d", i), out_data, mk(32'h1000 + 32'(4 * i)));
    end
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("stream_empty", 64'(empty), 64'd1);

    // Keep flush with pop and push: 0x104 retained, 0x10C dropped; KEEP_DS=0 empties.
    applyStimulus(1'b1, mk(32'h100), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk(32'h104), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk(32'h108), 1'b0, 1'b0, 1'b0);
    checkOutput("kf_pre_count", 64'(count), 64'd3);
    checkOutput("kf_pre_count0", 64'(count0), 64'd3);
    applyStimulus(1'b1, mk(32'h10C), 1'b1, 1'b1, 1'b1);
    checkOutput("kf_count", 64'(count), 64'd1);
    checkOutput("kf_head", out_data, mk(32'h104));
    checkOutput("kf_ds", 64'(ds_pending), 64'd0);
    checkOutput("nods_count", 64'(count0), 64'd0);
    checkOutput("nods_empty", 64'(empty0), 64'd1);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("kf_dropped", 64'(empty), 64'd1);

    // Delay slot not yet fetched: ds_pending survives a second keep flush, not a full flush.
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("ds_set", 64'(ds_pending), 64'd1);
    checkOutput("ds_set_empty", 64'(empty), 64'd1);
    checkOutput("nods_ds", 64'(ds_pending0), 64'd0);
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("ds_second_keep", 64'(ds_pending), 64'd1);
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("ds_full_flush", 64'(ds_pending), 64'd0);
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("ds_reset", 64'(ds_pending), 64'd1);
    applyStimulus(1'b1, mk(32'h204), 1'b0, 1'b0, 1'b0);
    checkOutput("ds_clear", 64'(ds_pending), 64'd0);
    checkOutput("ds_head", out_data, mk(32'h204));
    applyStimulus(1'b1, mk(32'h300), 1'b0, 1'b0, 1'b0);
    checkOutput("ds_count2", 64'(count), 64'd2);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("ds_second", out_data, mk(32'h300));
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("ds_drained", 64'(empty), 64'd1);

    // Keep flush without pop retains the head even when a push arrives.
    applyStimulus(1'b1, mk(32'h400), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk(32'h404), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk(32'h408), 1'b0, 1'b1, 1'b1);
    checkOutput("kf_nopop_count", 64'(count), 64'd1);
    checkOutput("kf_nopop_head", out_data, mk(32'h400));
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

    // Last entry popped during keep flush: the same-cycle push becomes the delay slot.
    applyStimulus(1'b1, mk(32'h500), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk(32'h504), 1'b1, 1'b1, 1'b1);
    checkOutput("kf_push_count", 64'(count), 64'd1);
    checkOutput("kf_push_head", out_data, mk(32'h504));
    checkOutput("kf_push_ds", 64'(ds_pending), 64'd0);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

    // Full flush with a same-cycle pop leaves nothing behind.
    applyStimulus(1'b1, mk(32'h600), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk(32'h604), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk(32'h608), 1'b1, 1'b1, 1'b0);
    checkOutput("ff_pop_empty", 64'(empty), 64'd1);

    // Reset wins over flush and a same-cycle push.
    applyStimulus(1'b1, mk(32'h700), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk(32'h704), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk(32'h708), 1'b0, 1'b0, 1'b0);
    checkOutput("rf_pre_count", 64'(count), 64'd3);
    rst = 1'b1;
    applyStimulus(1'b1, mk(32'h70C), 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    checkOutput("rf_count", 64'(count), 64'd0);
    checkOutput("rf_empty", 64'(empty), 64'd1);
    checkOutput("rf_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rf_ds", 64'(ds_pending), 64'd0);
    checkOutput("rf_out_data", out_data, 64'd0);
    applyStimulus(1'b1, mk(32'h800), 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_head", out_data, mk(32'h800));
    checkOutput("post_rst_count", 64'(count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_inst_queue.md
# id_inst_queue

Parametrised instruction queue between the fetch and decode stages. It buffers {pc, inst} words so the fetch side keeps running while decode stalls. On a taken branch it flushes wrong-path fetches and can keep exactly one delay-slot instruction. It replaces the single `if_to_id_bus` holding register with a DEPTH-entry circular buffer that uses a valid/ready handshake on both sides.

## Interface
Parameters:
- DEPTH, default 4: number of entries; must be a power of two and at least 2.
- DATA_W, default 64: entry width, packed as {pc[63:32], inst[31:0]} at the default width.
- KEEP_DS, default 1: 1 enables delay-slot retention on flush; 0 makes every flush a full flush.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- in_valid, input, 1: fetch presents a word.
- in_ready, output, 1: queue can accept a word; equals ~full.
- in_data, input, DATA_W: fetched {pc, inst}.
- out_valid, output, 1: head entry is valid; equals ~empty.
- out_ready, input, 1: decode consumes the head this cycle.
- out_data, output, DATA_W: head entry, mem[rd_ptr].
- flush, input, 1: branch resolved taken in decode; one-cycle pulse.
- flush_keep, input, 1: qualifies flush; keep the delay slot. Ignored when KEEP_DS=0.
- count, output, $clog2(DEPTH)+1: occupancy, 0..DEPTH.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- ds_pending, output, 1: waiting for a delay-slot word not yet fetched.

## Operation
- Storage: DEPTH x DATA_W register array. wr_ptr and rd_ptr are each $clog2(DEPTH)+1 bits, with the MSB as the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (index bits equal) and (wrap bits differ).
  - count = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
- push = in_valid & in_ready & ~rst.
- pop = out_valid & out_ready & ~rst.
- Push and pop may occur in the same cycle. count is then unchanged and both pointers advance.
- No fall-through: a word pushed into an empty queue appears on out_data one cycle later.
- No push-through when full: in_ready depends only on registered state, never on out_ready.
- Full flush (flush & ~(KEEP_DS & flush_keep)):
  - rd_ptr <= wr_ptr, so count becomes 0.
  - A push in the same cycle is discarded.
  - ds_pending <= 0.
  - A pop in the same cycle is still a legal consumption.
- Keep flush (flush & KEEP_DS & flush_keep): the retained entry is the oldest entry not popped this cycle (rd_ptr if no pop, rd_ptr+1 if pop).
  - If that entry exists: it becomes the only entry, by writing it to mem[rd_ptr'] with wr_ptr <= rd_ptr'+1. Any same-cycle push is discarded.
  - Else, if a push occurs this cycle: the pushed word is the only entry.
  - Else: set ds_pending and leave the queue empty.
- ds_pending set:
  - The next accepted push is stored normally and clears ds_pending.
  - A second keep flush leaves ds_pending set.
  - A full flush clears it.
- Simultaneous flush and rst: rst wins.

## Timing
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, in_ready=1, out_valid=0, ds_pending=0. out_data is don't-care but must be X-free, so clear entry 0 on reset.
- Pushes and pops are ignored while rst=1. The first legal push is in the cycle after rst falls.
- Latency:
  - Push to out_valid: 1 cycle.
  - Pop to next head visible: same edge.
  - Flush to queue state: visible the cycle after flush.
- All outputs except out_data are decoded from registered pointers. out_data is a DEPTH:1 mux on rd_ptr. There is no combinational in->out path.
- Pointer wrap: the index wraps modulo DEPTH and the wrap bit toggles. Sustaining one push and one pop per cycle at full throughput for more than 2*DEPTH cycles must not corrupt count.

## Test plan
- Reset, then push pc=0xBFC00000..0xBFC0000C with out_ready=0 (DEPTH=4): full=1 and in_ready=0 after the 4th push; a 5th push is ignored; draining yields the 4 words in order and then empty=1.
- Continuous push and pop for 20 cycles, pc incrementing by 4: count stays 1 after the first cycle, no word is lost or duplicated, and pointers wrap at least twice.
- Queue holds 0x100,0x104,0x108; pop 0x100 with flush=1, flush_keep=1, push 0x10C: the next cycle shows count=1, out_data pc=0x104, and 0x10C is dropped.
- Empty queue, keep flush with no push: ds_pending=1. Push 0x204, then push 0x300: ds_pending clears on the first push; the queue then holds 0x204, 0x300.
- KEEP_DS=0 build with queue count=3 and flush=1, flush_keep=1: the next cycle count=0 and the same-cycle push is dropped.
- Queue holds 3 entries with rst and flush asserted together: the next cycle shows all reset values and a push in the rst cycle is ignored.
